// File: rtl/soc_debug_capture_in.sv
// Avalon-MM host reader for pipeline byte stream.
// Bytes are buffered in a FIFO, popped via DATA, with status and IRQ.
module soc_debug_capture_in #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]         count, count_n;
  logic                  ovf, ovf_n;
  logic [1:0]            irqen, irqen_n;

  logic rd, wr, empty, full, pop, push, drop;
  logic flush, ovf_clr, empty_n;
  logic unused_ok;

  assign unused_ok = ^writedata[31:2];

  assign rd      = chipselect & ~read_n;
  assign wr      = chipselect & ~write_n;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd & (address == 2'd0) & ~empty;
  assign push    = in_valid & (~full | pop);
  assign drop    = in_valid & full & ~pop;
  assign flush   = wr & (address == 2'd3) & writedata[0];
  assign ovf_clr = wr & (address == 2'd3) & writedata[1];

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    irqen_n  = irqen;
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      wr_ptr_n = wr_ptr + DEPTH_LOG2'(push);
      rd_ptr_n = rd_ptr + DEPTH_LOG2'(pop);
      count_n  = count + CW'(push) - CW'(pop);
    end
    // a new drop beats a clear in the same cycle
    ovf_n = drop | (ovf & ~ovf_clr);
    if (wr && address == 2'd2)
      irqen_n = writedata[1:0];
    empty_n = (count_n == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irqen  <= 2'b00;
      irq    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      ovf    <= ovf_n;
      irqen  <= irqen_n;
      irq    <= (irqen_n[0] & ~empty_n)
              | (irqen_n[1] & ovf_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= in_data;
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: if (!empty) readdata[7:0] = mem[rd_ptr];
      2'd1: begin
        readdata[DEPTH_LOG2:0] = count;
        readdata[16] = empty;
        readdata[17] = full;
        readdata[18] = ovf;
      end
      2'd2: readdata[1:0] = irqen;
      2'd3: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_debug_capture_in.sv
// Directed scoreboard bench for soc_debug_capture_in.
// A byte queue models the FIFO; pops are compared against it.
module tb_soc_debug_capture_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic movf = 1'b0;

  soc_debug_capture_in #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .in_data(in_data), .in_valid(in_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp();
    logic [31:0] s = '0;
    s[4:0] = 5'(q.size());
    s[16]  = (q.size() == 0);
    s[17]  = (q.size() == 16);
    s[18]  = movf;
    return s;
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (q.size() < 16) q.push_back(b);
    else movf = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    model_push(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1 d = readdata;
    @(posedge clk);
    #1 chipselect = 1'b0;
    read_n = 1'b1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = v;
    @(posedge clk);
    #1 chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
    rd_reg(2'd0, d);
    check(tag, d, e);
  endtask

  task automatic stat_check(input string tag);
    logic [31:0] d;
    rd_reg(2'd1, d);
    check(tag, d, stat_exp());
  endtask

  initial begin
    logic [31:0] d;
    // 1 reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_irq", {31'h0, irq}, 32'h0);
    stat_check("reset_stat");
    check("reset_stat_const", stat_exp(), 32'h0001_0000);
    pop_check("reset_data");

    // 2 two bytes
    push_byte(8'hA5);
    push_byte(8'h3C);
    stat_check("two_stat2");
    pop_check("two_pop_a5");
    stat_check("two_stat1");
    pop_check("two_pop_3c");
    stat_check("two_stat0");
    pop_check("empty_pop");

    // 3 overflow
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    stat_check("ovf_stat");
    check("ovf_stat_const", stat_exp(), 32'h0006_0010);
    for (int i = 0; i < 16; i++) pop_check("ovf_pop");
    stat_check("ovf_sticky");
    wr_reg(2'd3, 32'h2);
    movf = 1'b0;
    stat_check("ovf_cleared");

    // 4 push and pop together at full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    stat_check("full_stat");
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 2'd0;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    #1 check("full_pushpop", readdata, {24'h0, q.pop_front()});
    q.push_back(8'h77);
    @(posedge clk);
    #1 chipselect = 1'b0;
    read_n   = 1'b1;
    in_valid = 1'b0;
    stat_check("full_after_pp");
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    stat_check("full_drained");

    // 5 irq on not-empty
    wr_reg(2'd2, 32'h1);
    rd_reg(2'd2, d);
    check("irqen_rd", d, 32'h1);
    check("irq_idle", {31'h0, irq}, 32'h0);
    push_byte(8'h11);
    check("irq_set", {31'h0, irq}, 32'h1);
    pop_check("irq_pop");
    check("irq_clr", {31'h0, irq}, 32'h0);
    wr_reg(2'd2, 32'h0);

    // 6 flush then wrap
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wr_reg(2'd3, 32'h3);
    q.delete();
    movf = 1'b0;
    stat_check("flush_stat");
    pop_check("flush_data");
    for (int i = 0; i < 40; i++) begin
      push_byte(8'h80 + 8'(i));
      pop_check("wrap_pop");
    end
    stat_check("wrap_stat");

    // reset mid-transfer
    push_byte(8'h55);
    push_byte(8'h66);
    @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    pop_check("rst_mid_data");
    stat_check("rst_mid_stat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
